// File: rtl/div_pkg.sv
// Shared defaults, FSM state encoding and counter sizing for the 40-by-8
// restoring divider.
package div_pkg;

    localparam int DIVIDEND_W_DEF = 40;
    localparam int DIVISOR_W_DEF  = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // The counter must hold the value DIVIDEND_W itself, hence the +1.
    function automatic int cnt_width(input int dividend_w);
        return $clog2(dividend_w + 1);
    endfunction

    localparam int CNT_W_DEF = cnt_width(DIVIDEND_W_DEF);

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift a dividend bit into the partial
// remainder and subtract the divisor when it fits.
module div_step
    import div_pkg::*;
#(
    parameter int DIVISOR_W = DIVISOR_W_DEF
) (
    input  logic [DIVISOR_W-1:0] rem_i,
    input  logic                 bit_i,
    input  logic [DIVISOR_W-1:0] divisor_i,
    output logic [DIVISOR_W-1:0] rem_o,
    output logic                 q_o
);

    logic [DIVISOR_W:0] trial;

    // One extra bit keeps the compare exact. When the subtract happens, the
    // true difference is below the divisor, so wrapping in DIVISOR_W bits is exact.
    always_comb begin
        trial = {rem_i, bit_i};
        q_o   = (trial >= {1'b0, divisor_i});
        rem_o = q_o ? (trial[DIVISOR_W-1:0] - divisor_i) : trial[DIVISOR_W-1:0];
    end

endmodule

// File: rtl/div_40by8.sv
// Fixed-latency unsigned restoring divider: one quotient bit per clock,
// MSB first, with a zero-divisor shortcut straight to DONE.
module div_40by8
    import div_pkg::*;
#(
    parameter int DIVIDEND_W = DIVIDEND_W_DEF,
    parameter int DIVISOR_W  = DIVISOR_W_DEF
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  busy,
    output logic                  done,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_zero,
    output logic                  fits32
);

    localparam int CNT_W = cnt_width(DIVIDEND_W);

    state_e                state_q, state_d;
    logic [DIVIDEND_W-1:0] work_q, work_d;
    logic [DIVISOR_W-1:0]  dsr_q, dsr_d;
    logic [DIVISOR_W-1:0]  rem_q, rem_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DIVIDEND_W-1:0] quotient_q, quotient_d;
    logic [DIVISOR_W-1:0]  remainder_q, remainder_d;
    logic                  div_zero_q, div_zero_d;
    logic                  fits32_q, fits32_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic [DIVISOR_W-1:0]  step_rem;
    logic                  step_q;

    // work_q shifts dividend bits out of the top while quotient bits enter at
    // the bottom, so after DIVIDEND_W steps it holds the quotient.
    div_step #(
        .DIVISOR_W (DIVISOR_W)
    ) u_step (
        .rem_i     (rem_q),
        .bit_i     (work_q[DIVIDEND_W-1]),
        .divisor_i (dsr_q),
        .rem_o     (step_rem),
        .q_o       (step_q)
    );

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves a
        // value unassigned, which would infer a latch.
        state_d     = state_q;
        work_d      = work_q;
        dsr_d       = dsr_q;
        rem_d       = rem_q;
        cnt_d       = cnt_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        div_zero_d  = div_zero_q;
        fits32_d    = fits32_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (divisor != '0) begin
                        work_d  = dividend;
                        dsr_d   = divisor;
                        rem_d   = '0;
                        cnt_d   = CNT_W'(DIVIDEND_W);
                        state_d = ST_RUN;
                    end else begin
                        quotient_d  = '1;
                        remainder_d = dividend[DIVISOR_W-1:0];
                        div_zero_d  = 1'b1;
                        fits32_d    = 1'b0;
                        state_d     = ST_DONE;
                    end
                end
            end
            ST_RUN: begin
                work_d = {work_q[DIVIDEND_W-2:0], step_q};
                rem_d  = step_rem;
                cnt_d  = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    quotient_d  = work_d;
                    remainder_d = step_rem;
                    div_zero_d  = 1'b0;
                    fits32_d    = ((work_d >> 32) == '0);
                    state_d     = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // busy and done are registered copies of the next state so that
        // every output comes straight from a flop.
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    // NOTE: every register, operands and counter included, is cleared by the
    // asynchronous reset so an abandoned division leaves nothing behind.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= ST_IDLE;
            work_q      <= '0;
            dsr_q       <= '0;
            rem_q       <= '0;
            cnt_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            div_zero_q  <= 1'b0;
            fits32_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so all flops update together
            // from the values present before the edge.
            state_q     <= state_d;
            work_q      <= work_d;
            dsr_q       <= dsr_d;
            rem_q       <= rem_d;
            cnt_q       <= cnt_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            div_zero_q  <= div_zero_d;
            fits32_q    <= fits32_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign div_zero  = div_zero_q;
    assign fits32    = fits32_q;

endmodule

// File: tb/tb_div_40by8.sv
// Directed self-checking bench for div_40by8: latency, results, zero
// divisor, ignored starts and mid-run reset.
module tb_div_40by8;

    logic        clk;
    logic        nrst;
    logic        start;
    logic [39:0] dividend;
    logic [7:0]  divisor;
    logic        busy;
    logic        done;
    logic [39:0] quotient;
    logic [7:0]  remainder;
    logic        div_zero;
    logic        fits32;

    int n_cmp = 0;
    int n_err = 0;

    div_40by8 dut (
        .clk       (clk),
        .nrst      (nrst),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero),
        .fits32    (fits32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents operands with start for one edge (E0); returns at E0+1.
    task automatic launch(input logic [39:0] dvd, input logic [7:0] dsr);
        dividend = dvd;
        divisor  = dsr;
        start    = 1'b1;
        step();
        start    = 1'b0;
    endtask

    // Counts edges until done is seen (bounded) and busy samples on the way.
    task automatic wait_done(output int n, output int nb);
        n  = 0;
        nb = busy ? 1 : 0;
        while (done !== 1'b1 && n < 100) begin
            step();
            n++;
            if (busy === 1'b1) nb++;
        end
    endtask

    int lat;
    int nbusy;
    int pulses;

    initial begin
        nrst     = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) step();
        check("rst_busy",      40'(busy),      40'd0);
        check("rst_done",      40'(done),      40'd0);
        check("rst_quotient",  quotient,       40'd0);
        check("rst_remainder", 40'(remainder), 40'd0);
        check("rst_div_zero",  40'(div_zero),  40'd0);
        check("rst_fits32",    40'(fits32),    40'd0);
        nrst = 1'b1;
        step();

        // 0x10000 / 0x10
        launch(40'h00_0001_0000, 8'h10);
        check("a_busy_e0", 40'(busy), 40'd1);
        wait_done(lat, nbusy);
        check("a_latency",   40'(lat),       40'd40);
        check("a_quotient",  quotient,       40'h00_0000_1000);
        check("a_remainder", 40'(remainder), 40'h00);
        check("a_fits32",    40'(fits32),    40'd1);
        check("a_div_zero",  40'(div_zero),  40'd0);
        step();

        // 100 / 7, with busy duration and single-cycle done
        launch(40'd100, 8'd7);
        wait_done(lat, nbusy);
        check("b_latency",   40'(lat),       40'd40);
        check("b_busy_len",  40'(nbusy),     40'd41);
        check("b_quotient",  quotient,       40'd14);
        check("b_remainder", 40'(remainder), 40'd2);
        step();
        check("b_done_gone", 40'(done),      40'd0);
        check("b_busy_gone", 40'(busy),      40'd0);
        repeat (3) step();
        check("b_hold_quo",  quotient,       40'd14);

        // all-ones / 1
        launch(40'hFF_FFFF_FFFF, 8'h01);
        wait_done(lat, nbusy);
        check("c_quotient",  quotient,       40'hFF_FFFF_FFFF);
        check("c_remainder", 40'(remainder), 40'd0);
        check("c_fits32",    40'(fits32),    40'd0);
        step();

        // zero divisor
        launch(40'h55, 8'h00);
        wait_done(lat, nbusy);
        check("d_latency",   40'(lat),       40'd0);
        check("d_quotient",  quotient,       40'hFF_FFFF_FFFF);
        check("d_remainder", 40'(remainder), 40'h55);
        check("d_div_zero",  40'(div_zero),  40'd1);
        check("d_fits32",    40'(fits32),    40'd0);
        step();
        check("d_done_gone", 40'(done),      40'd0);

        // 250 / 9 with a 1000 / 3 start pulsed mid-run
        launch(40'd250, 8'd9);
        repeat (10) step();
        dividend = 40'd1000;
        divisor  = 8'd3;
        start    = 1'b1;
        step();
        start    = 1'b0;
        dividend = 40'hAB;
        divisor  = 8'd0;
        wait_done(lat, nbusy);
        check("e_latency",   40'(lat),       40'd29);
        check("e_quotient",  quotient,       40'd27);
        check("e_remainder", 40'(remainder), 40'd7);
        check("e_div_zero",  40'(div_zero),  40'd0);
        repeat (3) step();
        check("e_no_queue",  40'(busy),      40'd0);
        check("e_hold_quo",  quotient,       40'd27);

        // reset at RUN step 20
        launch(40'd200, 8'd3);
        repeat (19) step();
        check("f_busy_pre",  40'(busy),      40'd1);
        nrst = 1'b0;
        #1;
        check("f_busy",      40'(busy),      40'd0);
        check("f_done",      40'(done),      40'd0);
        check("f_quotient",  quotient,       40'd0);
        check("f_remainder", 40'(remainder), 40'd0);
        check("f_div_zero",  40'(div_zero),  40'd0);
        check("f_fits32",    40'(fits32),    40'd0);
        repeat (2) step();
        nrst   = 1'b1;
        pulses = 0;
        for (int i = 0; i < 45; i++) begin
            step();
            if (done === 1'b1) pulses++;
        end
        check("f_no_done",   40'(pulses),    40'd0);
        launch(40'd100, 8'd7);
        wait_done(lat, nbusy);
        check("f_latency",   40'(lat),       40'd40);
        check("f_quotient",  quotient,       40'd14);
        check("f_remainder", 40'(remainder), 40'd2);
        step();

        // start held through RUN and DONE: taken again only from IDLE
        dividend = 40'd100;
        divisor  = 8'd7;
        start    = 1'b1;
        step();
        wait_done(lat, nbusy);
        check("g_latency",   40'(lat),       40'd40);
        check("g_quotient",  quotient,       40'd14);
        dividend = 40'd50;
        divisor  = 8'd5;
        step();
        check("g_idle_busy", 40'(busy),      40'd0);
        step();
        start    = 1'b0;
        check("g_accepted",  40'(busy),      40'd1);
        wait_done(lat, nbusy);
        check("g2_latency",  40'(lat),       40'd40);
        check("g2_quotient", quotient,       40'd10);
        check("g2_remainder", 40'(remainder), 40'd0);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/div_40by8.md
DIV_40BY8 -- requirements
Module: div_40by8

Interface
REQ-001 The block SHALL have parameter DIVIDEND_W, default 40, meaning dividend and quotient width in bits.
REQ-002 The block SHALL have parameter DIVISOR_W, default 8, meaning divisor and remainder width in bits.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port nrst, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port start, input, 1 bit: request a division; honoured only in IDLE.
REQ-006 The block SHALL have port dividend, input, DIVIDEND_W bits: unsigned dividend, sampled with an accepted start.
REQ-007 The block SHALL have port divisor, input, DIVISOR_W bits: unsigned divisor, sampled with an accepted start.
REQ-008 The block SHALL have port busy, output, 1 bit: high in RUN and DONE.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-010 The block SHALL have port quotient, output, DIVIDEND_W bits: registered unsigned quotient.
REQ-011 The block SHALL have port remainder, output, DIVISOR_W bits: registered unsigned remainder.
REQ-012 The block SHALL have port div_zero, output, 1 bit: the last result came from a zero divisor.
REQ-013 The block SHALL have port fits32, output, 1 bit: quotient[DIVIDEND_W-1:32] equals 0, i.e. the result is a valid 32-bit multiplicand.

Function
REQ-014 The FSM SHALL have states IDLE, RUN and DONE.
REQ-015 IDLE with start=1 and divisor!=0 SHALL capture both operands, clear the partial remainder, load an iteration counter with DIVIDEND_W, and go to RUN.
REQ-016 IDLE with start=1 and divisor==0 SHALL go straight to DONE with quotient all-ones, remainder=dividend[DIVISOR_W-1:0], div_zero=1, and fits32=0.
REQ-017 RUN SHALL perform one restoring step per cycle, MSB first: shift in the next dividend bit, subtract divisor when the trial remainder >= divisor, and shift the result bit into the quotient.
REQ-018 The trial remainder SHALL be DIVISOR_W+1 bits wide so the compare never overflows.
REQ-019 RUN SHALL decrement the counter each cycle and go to DONE after exactly DIVIDEND_W steps.
REQ-020 DONE SHALL assert done for exactly one cycle, update quotient, remainder, div_zero and fits32 on entry, and return unconditionally to IDLE.
REQ-021 Latency SHALL be fixed: a start accepted at edge E0 gives done=1 in the cycle after edge E0+DIVIDEND_W (E40 by default); a zero divisor gives done=1 in the cycle after E0.
REQ-022 start SHALL be ignored in RUN and DONE, with no queueing and no operand corruption.
REQ-023 quotient, remainder, div_zero and fits32 SHALL hold their last values until the next DONE entry.
REQ-024 The dividend and divisor inputs MAY change freely after acceptance without affecting the result.
REQ-025 A start asserted in the same cycle that DONE returns to IDLE SHALL be accepted on the next edge, while the FSM is in IDLE.

Reset
REQ-026 nrst=0 SHALL immediately force the FSM to IDLE and all outputs to 0, and SHALL clear the operand, counter and partial-remainder registers.
REQ-027 A reset during RUN SHALL abandon the operation with no done pulse; the first start after nrst deasserts SHALL behave as from power-up.

Structure
REQ-028 A shared package div_pkg SHALL hold the DIVIDEND_W and DIVISOR_W defaults, the state encoding, and the counter width of $clog2(DIVIDEND_W+1).
REQ-029 The block SHALL use one combinational sub-module, div_step: inputs partial remainder, next dividend bit and divisor; outputs next remainder and quotient bit; instantiated once in RUN.
REQ-030 All outputs SHALL come directly from registers.

Verification
REQ-031 The bench SHALL check: dividend=0x0000010000, divisor=0x10 -> quotient=0x0000001000, remainder=0x00, fits32=1, div_zero=0, done in the cycle after the 40th edge following the start edge.
REQ-032 The bench SHALL check: dividend=100, divisor=7 -> quotient=14, remainder=2, done high for exactly one cycle, busy high for 41 cycles.
REQ-033 The bench SHALL check: dividend=0xFFFFFFFFFF, divisor=0x01 -> quotient=0xFFFFFFFFFF, remainder=0, fits32=0.
REQ-034 The bench SHALL check: dividend=0x55, divisor=0 -> quotient=0xFFFFFFFFFF, remainder=0x55, div_zero=1, done in the cycle after the start edge.
REQ-035 The bench SHALL check: 250/9 started, then start with 1000/3 pulsed mid-RUN -> result stays 27 r 7 and the second start is ignored.
REQ-036 The bench SHALL check: nrst pulsed low at RUN step 20 -> busy=0 and all outputs 0 at once, no done pulse; a new 100/7 then yields 14 r 2.
